// File: rtl/istft_frame_sched.sv
// istft_frame_sched: frame-level scheduler for the istft datapath.
// For each coefficient frame it pulses istft_full, streams NUM_COEFF
// coefficients from the coeff RAM into istft_coeff (one per cycle), and
// collects NUM_SAMP samples from istft_ready/istft_aud into the audio FIFO.
// It runs num_frames frames per start command and then pulses done.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, abort, num_frames           run control
//   frame_avail, frame_release         coeff buffer handshake
//   coeff_rd_en/addr/data              coeff RAM read port (1-cycle latency)
//   istft_full, istft_coeff            frame start pulse and coefficient stream
//   istft_ready, istft_aud             sample strobe (rising edge) and sample
//   aud_valid, aud_data, aud_rdy       downstream audio FIFO
//   busy, done, overflow, frame_cnt    status
module istft_frame_sched #(
  parameter int unsigned NUM_COEFF = 180,
  parameter int unsigned NUM_SAMP  = 2047,
  parameter int unsigned COEFF_W   = 28,
  parameter int unsigned AUD_W     = 16,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [15:0]        num_frames,
  input  logic               frame_avail,
  output logic               frame_release,
  output logic               coeff_rd_en,
  output logic [ADDR_W-1:0]  coeff_rd_addr,
  input  logic [COEFF_W-1:0] coeff_rd_data,
  output logic               istft_full,
  output logic [COEFF_W-1:0] istft_coeff,
  input  logic               istft_ready,
  input  logic [AUD_W-1:0]   istft_aud,
  output logic               aud_valid,
  output logic [AUD_W-1:0]   aud_data,
  input  logic               aud_rdy,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned CCNT_W = 9;
  localparam int unsigned SCNT_W = 12;
  localparam int unsigned FRM_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_STREAM, S_DRAIN, S_RELEASE, S_DONE
  } state_t;

  state_t             state, state_d;
  logic [CCNT_W-1:0]  coeff_cnt;
  logic [SCNT_W-1:0]  samp_cnt;
  logic [FRM_W-1:0]   num_frames_q;
  logic               ready_q;
  logic               samp_edge;
  logic               capture;

  // A sample is taken on each rising edge of istft_ready, only while a frame is in flight.
  assign samp_edge = istft_ready & ~ready_q;
  assign capture   = samp_edge & ((state == S_STREAM) || (state == S_DRAIN)) & ~abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and state-decoded outputs; coeff_cnt = k-1 in STREAM cycle k
  always_comb begin
    state_d       = state;
    busy          = (state != S_IDLE);
    istft_full    = 1'b0;
    istft_coeff   = '0;
    coeff_rd_en   = 1'b0;
    coeff_rd_addr = '0;
    frame_release = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = (num_frames == 16'd0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (frame_avail) state_d = S_LOAD;
      end
      S_LOAD: begin
        istft_full  = 1'b1;
        coeff_rd_en = 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        // RAM data for the previous address goes straight through to istft.
        istft_coeff = coeff_rd_data;
        if (coeff_cnt < CCNT_W'(NUM_COEFF - 1)) begin
          coeff_rd_en   = 1'b1;
          coeff_rd_addr = ADDR_W'(coeff_cnt + CCNT_W'(1));
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (samp_cnt >= SCNT_W'(NUM_SAMP)) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        frame_release = 1'b1;
        state_d = (FRM_W'(frame_cnt + FRM_W'(1)) == num_frames_q) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Counters, sample capture and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      aud_valid    <= 1'b0;
      aud_data     <= '0;
      overflow     <= 1'b0;
      frame_cnt    <= '0;
      num_frames_q <= '0;
      coeff_cnt    <= '0;
      samp_cnt     <= '0;
    end else begin
      ready_q   <= istft_ready;
      aud_valid <= capture & aud_rdy;
      if (capture) aud_data <= istft_aud;
      // istft cannot be stalled, so a sample with no FIFO room is lost.
      if (capture && !aud_rdy) overflow <= 1'b1;
      if (abort) begin
        coeff_cnt <= '0;
        samp_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              frame_cnt    <= '0;
              overflow     <= 1'b0;
              num_frames_q <= num_frames;
            end
          end
          S_LOAD: begin
            coeff_cnt <= '0;
            samp_cnt  <= '0;
          end
          S_STREAM: begin
            if (coeff_cnt != '1) coeff_cnt <= coeff_cnt + CCNT_W'(1);
          end
          S_RELEASE: frame_cnt <= frame_cnt + FRM_W'(1);
          default: ;
        endcase
        if (capture && samp_cnt != '1) samp_cnt <= samp_cnt + SCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_istft_frame_sched.sv
// Directed bench for istft_frame_sched: coeff RAM model, istft sample source
// driven from the stimulus sequence, and pulse/sample counters on the outputs.
module tb_istft_frame_sched;

  localparam int unsigned NUM_COEFF = 180;
  localparam int unsigned NUM_SAMP  = 2047;
  localparam int unsigned COEFF_W   = 28;
  localparam int unsigned AUD_W     = 16;
  localparam int unsigned ADDR_W    = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [15:0]        num_frames;
  logic               frame_avail;
  logic               frame_release;
  logic               coeff_rd_en;
  logic [ADDR_W-1:0]  coeff_rd_addr;
  logic [COEFF_W-1:0] coeff_rd_data;
  logic               istft_full;
  logic [COEFF_W-1:0] istft_coeff;
  logic               istft_ready;
  logic [AUD_W-1:0]   istft_aud;
  logic               aud_valid;
  logic [AUD_W-1:0]   aud_data;
  logic               aud_rdy;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [15:0]        frame_cnt;

  istft_frame_sched #(
    .NUM_COEFF(NUM_COEFF), .NUM_SAMP(NUM_SAMP), .COEFF_W(COEFF_W),
    .AUD_W(AUD_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_frames(num_frames), .frame_avail(frame_avail),
    .frame_release(frame_release), .coeff_rd_en(coeff_rd_en),
    .coeff_rd_addr(coeff_rd_addr), .coeff_rd_data(coeff_rd_data),
    .istft_full(istft_full), .istft_coeff(istft_coeff),
    .istft_ready(istft_ready), .istft_aud(istft_aud),
    .aud_valid(aud_valid), .aud_data(aud_data), .aud_rdy(aud_rdy),
    .busy(busy), .done(done), .overflow(overflow), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coeff RAM: word 0 = 8388608, everything else 0, one cycle read latency
  logic [COEFF_W-1:0] ram [256];
  always @(posedge clk) if (coeff_rd_en) coeff_rd_data <= ram[coeff_rd_addr];

  // Output event counters, sampled on the falling edge
  int n_valid = 0, n_sum = 0, n_full = 0, n_rel = 0, n_done = 0, n_rden = 0;
  always @(negedge clk) begin
    if (aud_valid) begin
      n_valid++;
      n_sum += int'(aud_data);
    end
    if (istft_full)    n_full++;
    if (frame_release) n_rel++;
    if (done)          n_done++;
    if (coeff_rd_en)   n_rden++;
  end

  int b_valid, b_sum, b_full, b_rel, b_done, b_rden;
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic snap();
    b_valid = n_valid; b_sum = n_sum; b_full = n_full;
    b_rel = n_rel; b_done = n_done; b_rden = n_rden;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int nf);
    num_frames = 16'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_full(input string tag, output logic got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (istft_full) got = 1'b1;
      else tick();
    end
    check({tag, "_full_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (done) found = 1'b1;
      else tick();
    end
    check({tag, "_done_seen"}, 64'(found), 64'd1);
  endtask

  // From the full pulse: check the coefficient stream and feed nsamp samples (value = index)
  task automatic run_frame(input string tag, input int drop_idx, input int nsamp);
    logic got;
    int   bad;
    wait_full(tag, got);
    if (got) begin
      check({tag, "_coeff_in_load"}, 64'(istft_coeff), 64'd0);
      bad = 0;
      fork
        begin
          for (int k = 1; k <= int'(NUM_COEFF) + 1; k++) begin
            tick();
            if (istft_coeff !== ((k == 1) ? 28'd8388608 : 28'd0)) bad++;
            if (istft_full) bad++;
          end
        end
        begin
          for (int i = 1; i <= nsamp; i++) begin
            tick();
            istft_ready = 1'b1;
            istft_aud   = AUD_W'(i);
            aud_rdy     = (i != drop_idx);
            tick();
            istft_ready = 1'b0;
            aud_rdy     = 1'b1;
          end
        end
      join
      check({tag, "_coeff_stream_errs"}, 64'(bad), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[0] = 28'd8388608;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_frames = 16'd0;
    frame_avail = 1'b1; istft_ready = 1'b0; istft_aud = '0; aud_rdy = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", 64'({istft_full, coeff_rd_en, aud_valid, done, frame_release, overflow}), 64'd0);
    check("rst_data", 64'({istft_coeff, aud_data, coeff_rd_addr, frame_cnt}), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // One frame
    snap();
    start_run(1);
    run_frame("f1", 0, int'(NUM_SAMP));
    wait_done("f1");
    check("f1_frame_cnt", 64'(frame_cnt), 64'd1);
    tick();
    check("f1_busy_after", 64'(busy), 64'd0);
    check("f1_full_pulses", 64'(n_full - b_full), 64'd1);
    check("f1_valid_cnt", 64'(n_valid - b_valid), 64'd2047);
    check("f1_sample_sum", 64'(n_sum - b_sum), 64'd2096128);
    check("f1_releases", 64'(n_rel - b_rel), 64'd1);
    check("f1_done_pulses", 64'(n_done - b_done), 64'd1);
    check("f1_overflow", 64'(overflow), 64'd0);

    // Three frames, buffer empty for 50 cycles before frames 2 and 3
    snap();
    start_run(3);
    run_frame("m1", 0, int'(NUM_SAMP));
    frame_avail = 1'b0;
    repeat (50) tick();
    check("m_wait1_busy", 64'(busy), 64'd1);
    check("m_wait1_full", 64'(n_full - b_full), 64'd1);
    check("m_wait1_rel", 64'(n_rel - b_rel), 64'd1);
    check("m_wait1_frame_cnt", 64'(frame_cnt), 64'd1);
    frame_avail = 1'b1;
    run_frame("m2", 0, int'(NUM_SAMP));
    frame_avail = 1'b0;
    repeat (50) tick();
    check("m_wait2_full", 64'(n_full - b_full), 64'd2);
    check("m_wait2_no_done", 64'(n_done - b_done), 64'd0);
    frame_avail = 1'b1;
    run_frame("m3", 0, int'(NUM_SAMP));
    wait_done("m");
    check("m_frame_cnt", 64'(frame_cnt), 64'd3);
    tick();
    check("m_releases", 64'(n_rel - b_rel), 64'd3);
    check("m_valid_cnt", 64'(n_valid - b_valid), 64'd6141);
    check("m_done_pulses", 64'(n_done - b_done), 64'd1);

    // Sample 10 dropped by backpressure
    snap();
    start_run(1);
    run_frame("ov", 10, int'(NUM_SAMP));
    check("ov_overflow_mid", 64'(overflow), 64'd1);
    wait_done("ov");
    tick();
    repeat (5) tick();
    check("ov_overflow_sticky", 64'(overflow), 64'd1);
    check("ov_valid_cnt", 64'(n_valid - b_valid), 64'd2046);
    check("ov_sample_sum", 64'(n_sum - b_sum), 64'd2096118);
    check("ov_releases", 64'(n_rel - b_rel), 64'd1);
    check("ov_frame_cnt", 64'(frame_cnt), 64'd1);

    // Zero frames: straight to DONE, which also shows start clearing overflow
    snap();
    start_run(0);
    check("z_overflow_cleared", 64'(overflow), 64'd0);
    check("z_done", 64'(done), 64'd1);
    check("z_frame_cnt", 64'(frame_cnt), 64'd0);
    tick();
    check("z_done_one_cycle", 64'(done), 64'd0);
    check("z_idle", 64'(busy), 64'd0);
    check("z_no_full", 64'(n_full - b_full), 64'd0);
    check("z_no_rden", 64'(n_rden - b_rden), 64'd0);

    // Abort at STREAM cycle 90
    begin
      logic got;
      snap();
      start_run(1);
      wait_full("ab", got);
      repeat (90) tick();
      check("ab_in_stream", 64'(coeff_rd_en), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_idle", 64'(busy), 64'd0);
      check("ab_coeff_zero", 64'(istft_coeff), 64'd0);
      check("ab_rden_off", 64'(coeff_rd_en), 64'd0);
      repeat (20) tick();
      check("ab_no_release", 64'(n_rel - b_rel), 64'd0);
      check("ab_no_done", 64'(n_done - b_done), 64'd0);
    end
    snap();
    start_run(1);
    run_frame("ar", 0, int'(NUM_SAMP));
    wait_done("ar");
    tick();
    check("ar_valid_cnt", 64'(n_valid - b_valid), 64'd2047);
    check("ar_releases", 64'(n_rel - b_rel), 64'd1);
    check("ar_frame_cnt", 64'(frame_cnt), 64'd1);

    // Async reset in DRAIN after sample 1000
    snap();
    start_run(1);
    run_frame("rs", 0, 1000);
    check("rs_in_drain", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_outs", 64'({istft_full, coeff_rd_en, aud_valid, done, frame_release, overflow}), 64'd0);
    check("rs_data", 64'({istft_coeff, aud_data, coeff_rd_addr, frame_cnt}), 64'd0);
    tick();
    check("rs_no_release", 64'(n_rel - b_rel), 64'd0);
    rst_n = 1'b1;
    tick();
    snap();
    start_run(1);
    run_frame("rc", 0, int'(NUM_SAMP));
    wait_done("rc");
    tick();
    check("rc_valid_cnt", 64'(n_valid - b_valid), 64'd2047);
    check("rc_sample_sum", 64'(n_sum - b_sum), 64'd2096128);
    check("rc_releases", 64'(n_rel - b_rel), 64'd1);
    check("rc_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
